pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding unit for the pipelined core. Sits beside the decode stage.
//  - Tracks in-flight destination registers in a shadow scoreboard pipeline.
//  - Selects forwarded operands for rs/rt from downstream stage results.
//  - Generates the load-use stall/bubble and the taken-redirect flush.
//  - Keeps a saturating stall counter for performance measurement.
// PARAMETERS
//  DATA_W      32  operand/result width
//  ADDR_W      5   register address width
//  FWD_STAGES  3   post-decode stages tracked (0=EX, 1=MEM, ..., FWD_STAGES-1=WB); min 1
//  LOAD_READY  1   first stage index at which a load's result is valid; 0..FWD_STAGES-1
//  CNT_W       16  stall counter width
// PORTS
//  clk           in   1                   rising-edge clock
//  reset         in   1                   synchronous, active-high reset
//  id_valid      in   1                   decode stage holds a real instruction
//  id_rs_addr    in   ADDR_W              source A register address
//  id_rt_addr    in   ADDR_W              source B register address
//  id_uses_rs    in   1                   instruction reads rs
//  id_uses_rt    in   1                   instruction reads rt
//  id_dst_addr   in   ADDR_W              destination register address
//  id_reg_wr_en  in   1                   instruction writes the register file
//  id_is_load    in   1                   instruction is a memory load
//  id_redirect   in   1                   decode resolved a taken jump/jr/branch
//  rf_rs_data    in   DATA_W              register-file read port 1
//  rf_rt_data    in   DATA_W              register-file read port 2
//  stage_result  in   FWD_STAGES*DATA_W   result of stage k in bits [k*DATA_W +: DATA_W]
//  op_a          out  DATA_W              forwarded rs operand
//  op_b          out  DATA_W              forwarded rt operand
//  stall         out  1                   hold the PC and the IF/ID register this cycle
//  bubble        out  1                   load a NOP into ID/EX this cycle
//  flush         out  1                   kill the IF/ID contents at the next edge
//  stall_count   out  CNT_W               number of stalled cycles, saturating
// BEHAVIOUR
//  - Scoreboard: FWD_STAGES entries {valid, dst, wr_en, is_load}. Every edge, entry k moves
//    to k+1 and the last entry retires. Entry 0 takes the ID instruction when
//    id_valid & ~stall; otherwise entry 0 takes an invalid entry (the bubble).
//  - Match(k, a): entry k valid & wr_en & dst==a & a!=0. Register 0 never matches.
//  - Forwarding is combinational. The lowest k with a match wins (youngest producer).
//    The operand is stage_result[k]. With no match, the operand is the rf data.
//  - The last stage forwards too. This covers a same-cycle regfile write followed by a read.
//  - Load-use: for a used operand whose winning entry is a load with k < LOAD_READY,
//    stall = bubble = 1 (qualified by id_valid). The stall repeats each cycle until the load
//    reaches LOAD_READY, so the stall lasts LOAD_READY-k cycles. LOAD_READY=0 never stalls.
//  - flush = id_redirect & id_valid & ~stall. A stalled redirect is not lost: it re-asserts
//    once the stall clears, because ID still holds the instruction.
//  - stall_count increments on every stall cycle and saturates at 2^CNT_W-1.
//  - Reset (synchronous): all entries invalid; stall_count=0. With no valid entries the
//    outputs follow as stall=0, bubble=0, flush=0, op_a=rf_rs_data, op_b=rf_rt_data.
//    Reset asserted mid-stall clears the stall on the next cycle.
//  - Latency: forwarding and hazard outputs are 0 cycles (combinational). The scoreboard
//    advances 1 stage per clock.
// STRUCTURE
//  - Shared header pipe_defs.vh holds these constants:
//    - stage indices: STG_EX=0, STG_MEM=1, STG_WB=2
//    - scoreboard field offsets
//    - REG_ZERO = 0
//  - Sub-module fwd_select (DATA_W, ADDR_W, FWD_STAGES): priority match and mux for one
//    operand. It returns the data, a hit flag and the winning-entry is_load/index.
//    It is instantiated twice, once for rs and once for rt.
//  - The scoreboard shift register, the stall/flush logic and the counter live in the top module.
// TESTING (defaults unless noted)
//  1. Producer at EX: add r3 in entry 0, ID reads rs=r3, stage_result[0]=32'h1234
//     -> op_a=32'h1234, stall=0.
//  2. Load-use: lw r4 in entry 0, ID uses rt=r4 -> cycle 1: stall=bubble=1.
//     Cycle 2: stall=0, op_b=stage_result[1], stall_count=1.
//     Repeat with LOAD_READY=2 -> 2 stall cycles, stall_count=2.
//  3. Write to r0 in entry 0, ID reads r0 with rf_rs_data=0 -> op_a=0, stall=0.
//  4. r5 in entries 0 and 2, results 32'hA and 32'hB -> op_a=32'hA (youngest wins).
//  5. Redirect during a load-use stall -> flush=0 while stall=1, then flush=1 on the
//     first unstalled cycle, exactly once.
//  6. Reset asserted mid-stall -> next cycle stall=0, op_a=rf_rs_data, stall_count=0.
//     Also force CNT_W=4 with 20 stalls -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
//------------------------------------------------------------------------------
// pipe_hazard_unit_pkg : shared constants for the hazard/forwarding unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_hazard_unit_pkg;

    // Post-decode stage indices
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // Scoreboard entry layout: {dst, is_load, wr_en, valid}
    localparam int SB_VALID = 0;
    localparam int SB_WR    = 1;
    localparam int SB_LOAD  = 2;
    localparam int SB_DST   = 3;

    localparam int REG_ZERO = 0;

    function automatic int sb_entry_w(input int addr_w);
        return SB_DST + addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_unit_if.sv
//------------------------------------------------------------------------------
// pipe_hazard_unit_if : decode-side signals of the hazard/forwarding unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_hazard_unit_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 16
) ();
    logic                         id_valid;
    logic [ADDR_W-1:0]            id_rs_addr;
    logic [ADDR_W-1:0]            id_rt_addr;
    logic                         id_uses_rs;
    logic                         id_uses_rt;
    logic [ADDR_W-1:0]            id_dst_addr;
    logic                         id_reg_wr_en;
    logic                         id_is_load;
    logic                         id_redirect;
    logic [DATA_W-1:0]            rf_rs_data;
    logic [DATA_W-1:0]            rf_rt_data;
    logic [FWD_STAGES*DATA_W-1:0] stage_result;
    logic [DATA_W-1:0]            op_a;
    logic [DATA_W-1:0]            op_b;
    logic                         stall;
    logic                         bubble;
    logic                         flush;
    logic [CNT_W-1:0]             stall_count;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        output id_dst_addr, id_reg_wr_en, id_is_load, id_redirect,
        output rf_rs_data, rf_rt_data, stage_result,
        input  op_a, op_b, stall, bubble, flush, stall_count
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        input  id_dst_addr, id_reg_wr_en, id_is_load, id_redirect,
        input  rf_rs_data, rf_rt_data, stage_result,
        output op_a, op_b, stall, bubble, flush, stall_count
    );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_unit_fwd_select.sv
//------------------------------------------------------------------------------
// pipe_hazard_unit_fwd_select : priority match + operand mux for one source
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_unit_fwd_select
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 3,
    parameter int IDX_W      = (FWD_STAGES > 1) ? $clog2(FWD_STAGES) : 1,
    parameter int ENT_W      = SB_DST + ADDR_W
) (
    input  wire logic [ADDR_W-1:0]            i_addr,
    input  wire logic [FWD_STAGES*ENT_W-1:0]  i_sb,
    input  wire logic [FWD_STAGES*DATA_W-1:0] i_stage_result,
    input  wire logic [DATA_W-1:0]            i_rf_data,
    output logic      [DATA_W-1:0]            o_data,
    output logic                              o_hit,
    output logic                              o_is_load,
    output logic      [IDX_W-1:0]             o_idx
);

    logic [ENT_W-1:0] w_ent;

    // Scan oldest to youngest so the lowest matching index overrides.
    always_comb begin
        o_data    = i_rf_data;
        o_hit     = 1'b0;
        o_is_load = 1'b0;
        o_idx     = '0;
        w_ent     = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            w_ent = i_sb[k*ENT_W +: ENT_W];
            if (w_ent[SB_VALID] && w_ent[SB_WR] &&
                (w_ent[SB_DST +: ADDR_W] == i_addr) &&
                (i_addr != ADDR_W'(REG_ZERO))) begin
                o_data    = i_stage_result[k*DATA_W +: DATA_W];
                o_hit     = 1'b1;
                o_is_load = w_ent[SB_LOAD];
                o_idx     = IDX_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
//------------------------------------------------------------------------------
// pipe_hazard_unit : scoreboard, operand forwarding, load-use stall and flush
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pipe_hazard_unit_if.slave hz
);

    localparam int ENT_W = sb_entry_w(ADDR_W);
    localparam int IDX_W = (FWD_STAGES > 1) ? $clog2(FWD_STAGES) : 1;
    localparam logic [IDX_W:0] C_LOAD_READY = (IDX_W + 1)'(LOAD_READY);

    logic [FWD_STAGES*ENT_W-1:0] r_sb;
    logic [CNT_W-1:0]            r_stall_cnt;
    logic [ENT_W-1:0]            w_new_ent;
    logic [DATA_W-1:0]           w_rs_data, w_rt_data;
    logic                        w_rs_hit, w_rt_hit, w_rs_load, w_rt_load;
    logic [IDX_W-1:0]            w_rs_idx, w_rt_idx;
    logic                        w_rs_haz, w_rt_haz, w_stall;

    pipe_hazard_unit_fwd_select #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES), .IDX_W(IDX_W), .ENT_W(ENT_W)
    ) u_fwd_rs (
        .i_addr(hz.id_rs_addr), .i_sb(r_sb), .i_stage_result(hz.stage_result),
        .i_rf_data(hz.rf_rs_data), .o_data(w_rs_data), .o_hit(w_rs_hit),
        .o_is_load(w_rs_load), .o_idx(w_rs_idx)
    );

    pipe_hazard_unit_fwd_select #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES), .IDX_W(IDX_W), .ENT_W(ENT_W)
    ) u_fwd_rt (
        .i_addr(hz.id_rt_addr), .i_sb(r_sb), .i_stage_result(hz.stage_result),
        .i_rf_data(hz.rf_rt_data), .o_data(w_rt_data), .o_hit(w_rt_hit),
        .o_is_load(w_rt_load), .o_idx(w_rt_idx)
    );

    // A load still short of LOAD_READY cannot be forwarded yet.
    assign w_rs_haz = hz.id_uses_rs & w_rs_hit & w_rs_load & ({1'b0, w_rs_idx} < C_LOAD_READY);
    assign w_rt_haz = hz.id_uses_rt & w_rt_hit & w_rt_load & ({1'b0, w_rt_idx} < C_LOAD_READY);
    assign w_stall  = hz.id_valid & (w_rs_haz | w_rt_haz);

    assign hz.op_a        = w_rs_data;
    assign hz.op_b        = w_rt_data;
    assign hz.stall       = w_stall;
    assign hz.bubble      = w_stall;
    assign hz.flush       = hz.id_redirect & hz.id_valid & ~w_stall;
    assign hz.stall_count = r_stall_cnt;

    always_comb begin
        w_new_ent                    = '0;
        w_new_ent[SB_VALID]          = hz.id_valid & ~w_stall;
        w_new_ent[SB_WR]             = hz.id_reg_wr_en;
        w_new_ent[SB_LOAD]           = hz.id_is_load;
        w_new_ent[SB_DST +: ADDR_W]  = hz.id_dst_addr;
    end

    generate
        if (FWD_STAGES == 1) begin : g_sb_single
            always_ff @(posedge clk) begin
                if (reset) r_sb <= '0;
                else       r_sb <= w_new_ent;
            end
        end else begin : g_sb_shift
            always_ff @(posedge clk) begin
                if (reset) r_sb <= '0;
                else       r_sb <= {r_sb[(FWD_STAGES-1)*ENT_W-1:0], w_new_ent};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
//------------------------------------------------------------------------------
// tb_pipe_hazard_unit : three configurations driven in lockstep, checked
// against an issue-history reference model.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_unit;

    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int dst;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_valid, t_urs, t_urt, t_wr, t_ld, t_redir;
    logic [4:0]  t_rs, t_rt, t_dst;
    logic [31:0] t_rfa, t_rfb;
    logic [95:0] t_sres;

    int   n_total = 0;
    int   n_bad   = 0;
    bit   chk_en  = 1'b0;
    int   cyc     = 0;
    rec_t hist [3][4096];
    int   rst_at [3] = '{0, 0, 0};
    int   nst    [3] = '{0, 0, 0};
    bit   exp_st [3] = '{0, 0, 0};
    int   lr     [3] = '{1, 2, 1};
    int   cw     [3] = '{16, 16, 4};

    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .CNT_W(16)) if0 ();
    pipe_hazard_unit_if #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .CNT_W(16)) if1 ();
    pipe_hazard_unit_if #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .CNT_W(4))  if2 ();

    assign if0.id_valid = t_valid;  assign if1.id_valid = t_valid;  assign if2.id_valid = t_valid;
    assign if0.id_rs_addr = t_rs;   assign if1.id_rs_addr = t_rs;   assign if2.id_rs_addr = t_rs;
    assign if0.id_rt_addr = t_rt;   assign if1.id_rt_addr = t_rt;   assign if2.id_rt_addr = t_rt;
    assign if0.id_uses_rs = t_urs;  assign if1.id_uses_rs = t_urs;  assign if2.id_uses_rs = t_urs;
    assign if0.id_uses_rt = t_urt;  assign if1.id_uses_rt = t_urt;  assign if2.id_uses_rt = t_urt;
    assign if0.id_dst_addr = t_dst; assign if1.id_dst_addr = t_dst; assign if2.id_dst_addr = t_dst;
    assign if0.id_reg_wr_en = t_wr; assign if1.id_reg_wr_en = t_wr; assign if2.id_reg_wr_en = t_wr;
    assign if0.id_is_load = t_ld;   assign if1.id_is_load = t_ld;   assign if2.id_is_load = t_ld;
    assign if0.id_redirect = t_redir; assign if1.id_redirect = t_redir; assign if2.id_redirect = t_redir;
    assign if0.rf_rs_data = t_rfa;  assign if1.rf_rs_data = t_rfa;  assign if2.rf_rs_data = t_rfa;
    assign if0.rf_rt_data = t_rfb;  assign if1.rf_rt_data = t_rfb;  assign if2.rf_rt_data = t_rfb;
    assign if0.stage_result = t_sres; assign if1.stage_result = t_sres; assign if2.stage_result = t_sres;

    pipe_hazard_unit #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .LOAD_READY(1), .CNT_W(16))
        dut0 (.clk(clk), .reset(rst), .hz(if0));
    pipe_hazard_unit #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .LOAD_READY(2), .CNT_W(16))
        dut1 (.clk(clk), .reset(rst), .hz(if1));
    pipe_hazard_unit #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(3), .LOAD_READY(1), .CNT_W(4))
        dut2 (.clk(clk), .reset(rst), .hz(if2));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Youngest issued writer of register a that is still within the tracked window.
    task automatic find_producer(input int m, input int a, output bit hit, output int age, output bit ld);
        hit = 0; age = 0; ld = 0;
        for (int k = 0; k < 3; k++) begin
            int idx = cyc - 1 - k;
            if (!hit && idx >= 0 && idx >= rst_at[m] && hist[m][idx].v && hist[m][idx].wr &&
                hist[m][idx].dst == a && a != 0) begin
                hit = 1; age = k; ld = hist[m][idx].ld;
            end
        end
    endtask

    task automatic model_chk(input int m, input logic [31:0] oa, input logic [31:0] ob,
                             input logic st, input logic bu, input logic fl, input logic [63:0] cnt);
        bit ha, hb, la, lb, es;
        int ka, kb;
        logic [31:0] ea, eb;
        longint mx, ec;
        find_producer(m, int'(t_rs), ha, ka, la);
        find_producer(m, int'(t_rt), hb, kb, lb);
        ea = ha ? t_sres[ka*32 +: 32] : t_rfa;
        eb = hb ? t_sres[kb*32 +: 32] : t_rfb;
        es = t_valid && ((t_urs && ha && la && ka < lr[m]) || (t_urt && hb && lb && kb < lr[m]));
        mx = (64'd1 << cw[m]) - 1;
        ec = (longint'(nst[m]) > mx) ? mx : longint'(nst[m]);
        exp_st[m] = es;
        if (chk_en) begin
            check_val($sformatf("d%0d_op_a", m), 64'(oa), 64'(ea));
            check_val($sformatf("d%0d_op_b", m), 64'(ob), 64'(eb));
            check_val($sformatf("d%0d_stall", m), 64'(st), 64'(es));
            check_val($sformatf("d%0d_bubble", m), 64'(bu), 64'(es));
            check_val($sformatf("d%0d_flush", m), 64'(fl), 64'(t_redir && t_valid && !es));
            check_val($sformatf("d%0d_count", m), cnt, 64'(ec));
        end
    endtask

    task automatic model_adv();
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                rst_at[m] = cyc + 1;
                nst[m] = 0;
                hist[m][cyc] = '{0, 0, 0, 0};
            end else begin
                hist[m][cyc] = '{t_valid && !exp_st[m], t_wr, t_ld, int'(t_dst)};
                if (exp_st[m]) nst[m]++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        #3;
        model_chk(0, if0.op_a, if0.op_b, if0.stall, if0.bubble, if0.flush, 64'(if0.stall_count));
        model_chk(1, if1.op_a, if1.op_b, if1.stall, if1.bubble, if1.flush, 64'(if1.stall_count));
        model_chk(2, if2.op_a, if2.op_b, if2.stall, if2.bubble, if2.flush, 64'(if2.stall_count));
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic nop();
        t_valid = 0; t_urs = 0; t_urt = 0; t_wr = 0; t_ld = 0; t_redir = 0;
        t_rs = 0; t_rt = 0; t_dst = 0;
        t_rfa = $urandom; t_rfb = $urandom;
        t_sres = {$urandom, $urandom, $urandom};
    endtask

    task automatic issue_load(input logic [4:0] d);
        nop(); t_valid = 1; t_dst = d; t_wr = 1; t_ld = 1;
    endtask

    task automatic rand_in();
        t_valid = ($urandom_range(0, 9) != 0);
        t_rs    = 5'($urandom_range(0, 7));
        t_rt    = 5'($urandom_range(0, 7));
        t_urs   = 1'($urandom_range(0, 1));
        t_urt   = 1'($urandom_range(0, 1));
        t_dst   = 5'($urandom_range(0, 7));
        t_wr    = ($urandom_range(0, 3) != 0);
        t_ld    = ($urandom_range(0, 2) == 0);
        t_redir = ($urandom_range(0, 7) == 0);
        t_rfa   = $urandom;
        t_rfb   = $urandom;
        t_sres  = {$urandom, $urandom, $urandom};
        rst     = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        rst = 1;
        step();
        chk_en = 1;
        step();
        rst = 0;
        nop(); step();

        // Producer in EX forwards its result
        nop(); t_valid = 1; t_dst = 3; t_wr = 1; step();
        nop(); t_valid = 1; t_rs = 3; t_urs = 1; t_sres[31:0] = 32'h1234;
        #2; check_val("t1_op_a", 64'(if0.op_a), 64'h1234); check_val("t1_stall", 64'(if0.stall), 0);
        step();

        // Load-use: one stall cycle at LOAD_READY=1, two at LOAD_READY=2
        issue_load(5'd4); step();
        nop(); t_valid = 1; t_rt = 4; t_urt = 1;
        #2; check_val("t2_stall", 64'(if0.stall), 1); check_val("t2_bubble", 64'(if0.bubble), 1);
        step();
        #2; check_val("t2_stall2", 64'(if0.stall), 0); check_val("t2_op_b", 64'(if0.op_b), 64'(t_sres[63:32]));
        check_val("t2_cnt", 64'(if0.stall_count), 1); check_val("t2_lr2_stall", 64'(if1.stall), 1);
        step();
        #2; check_val("t2_lr2_free", 64'(if1.stall), 0); check_val("t2_lr2_cnt", 64'(if1.stall_count), 2);
        step();

        // Register 0 never forwards
        nop(); t_valid = 1; t_dst = 0; t_wr = 1; step();
        nop(); t_valid = 1; t_rs = 0; t_urs = 1; t_rfa = 0;
        #2; check_val("t3_op_a", 64'(if0.op_a), 0); check_val("t3_stall", 64'(if0.stall), 0);
        step();

        // Youngest producer wins
        nop(); t_valid = 1; t_dst = 5; t_wr = 1; step();
        nop(); step();
        nop(); t_valid = 1; t_dst = 5; t_wr = 1; step();
        nop(); t_valid = 1; t_rs = 5; t_urs = 1; t_sres[31:0] = 32'hA; t_sres[95:64] = 32'hB;
        #2; check_val("t4_op_a", 64'(if0.op_a), 64'hA);
        step();

        // Redirect held through a load-use stall flushes once it clears
        issue_load(5'd4); step();
        nop(); t_valid = 1; t_rt = 4; t_urt = 1; t_redir = 1;
        #2; check_val("t5_stall", 64'(if0.stall), 1); check_val("t5_flush0", 64'(if0.flush), 0);
        step();
        #2; check_val("t5_flush1", 64'(if0.flush), 1);
        step();
        nop(); step();

        // Reset in the middle of a stall
        issue_load(5'd4); step();
        nop(); t_valid = 1; t_rs = 4; t_urs = 1;
        #2; check_val("t6_stall", 64'(if0.stall), 1);
        rst = 1; step(); rst = 0;
        #2; check_val("t6_stall_clr", 64'(if0.stall), 0); check_val("t6_op_a", 64'(if0.op_a), 64'(t_rfa));
        check_val("t6_cnt", 64'(if0.stall_count), 0);
        step();

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            issue_load(5'd4); step();
            nop(); t_valid = 1; t_rt = 4; t_urt = 1; step();
            step();
        end
        nop();
        #2; check_val("sat_cnt4", 64'(if2.stall_count), 15); check_val("sat_cnt16", 64'(if0.stall_count), 20);
        step();

        for (int i = 0; i < 1500; i++) begin
            rand_in();
            step();
        end
        rst = 0;
        nop(); step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
